// File: rtl/ipfw_hdr_filter.sv
// IPv4 header filter: buffers the 5-word header, matches one address field against
// a masked rule, then replays header + body or discards the whole packet.
module ipfw_hdr_filter #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WORDS  = 5
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [31:0]           cfg_rule_addr,
  input  logic [31:0]           cfg_rule_mask,
  input  logic [31:0]           cfg_ctrl,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [31:0]           pass_count,
  output logic [31:0]           drop_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_DECIDE = 3'd1,
    ST_REPLAY = 3'd2,
    ST_BODY   = 3'd3,
    ST_DROP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(HDR_WORDS - 1);

  state_t                r_state, w_state_nx;
  logic [DATA_WIDTH-1:0] r_hdr_buf [0:HDR_WORDS-1];
  logic [2:0]            r_hidx, r_ridx;
  logic                  r_hdr_only, r_rdy_en;
  logic [31:0]           r_rule_addr, r_rule_mask;
  logic [2:0]            r_ctrl;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid, r_m_tlast;
  logic [31:0]           r_pass_cnt, r_drop_cnt;

  logic                  w_s_tready, w_in_fire, w_out_free;
  logic [DATA_WIDTH-1:0] w_sel;
  logic                  w_match, w_drop, w_pass_inc, w_drop_inc;
  logic                  w_unused_ctrl;

  // Both streams use valid/ready: a beat moves only on a cycle with valid & ready high;
  // m_tvalid/m_tdata/m_tlast come straight from flops and never look at m_tready.
  assign w_in_fire     = s_tvalid & w_s_tready;
  assign w_out_free    = ~r_m_tvalid | m_tready;
  assign w_sel         = r_ctrl[1] ? r_hdr_buf[4] : r_hdr_buf[3];
  assign w_match       = ((w_sel ^ r_rule_addr) & r_rule_mask) == '0;
  assign w_drop        = r_ctrl[0] & (r_ctrl[2] ? w_match : ~w_match);
  assign w_unused_ctrl = ^cfg_ctrl[31:3];

  always_comb begin
    w_s_tready = 1'b0;
    case (r_state)
      ST_HDR:  w_s_tready = r_rdy_en;
      ST_BODY: w_s_tready = r_rdy_en & w_out_free;
      ST_DROP: w_s_tready = r_rdy_en;
      default: w_s_tready = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= ST_HDR;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pass_inc = 1'b0;
    w_drop_inc = 1'b0;
    case (r_state)
      ST_HDR: begin
        if (w_in_fire) begin
          if (r_hidx == LAST_IDX) w_state_nx = ST_DECIDE;
          else if (s_tlast)       w_drop_inc = 1'b1;
        end
      end
      ST_DECIDE: begin
        if (!w_drop) begin
          w_state_nx = ST_REPLAY;
        end else if (r_hdr_only) begin
          w_drop_inc = 1'b1;
          w_state_nx = ST_HDR;
        end else begin
          w_state_nx = ST_DROP;
        end
      end
      ST_REPLAY: begin
        if (w_out_free && r_ridx == LAST_IDX) begin
          w_pass_inc = r_hdr_only;
          w_state_nx = r_hdr_only ? ST_HDR : ST_BODY;
        end
      end
      ST_BODY: begin
        if (w_in_fire && s_tlast) begin
          w_pass_inc = 1'b1;
          w_state_nx = ST_HDR;
        end
      end
      ST_DROP: begin
        if (w_in_fire && s_tlast) begin
          w_drop_inc = 1'b1;
          w_state_nx = ST_HDR;
        end
      end
      default: w_state_nx = ST_HDR;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_hidx      <= '0;
      r_ridx      <= '0;
      r_hdr_only  <= 1'b0;
      r_rule_addr <= '0;
      r_rule_mask <= '0;
      r_ctrl      <= '0;
      for (int i = 0; i < HDR_WORDS; i++) r_hdr_buf[i] <= '0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
    end else begin
      if (r_state == ST_HDR && w_in_fire) begin
        r_hdr_buf[r_hidx] <= s_tdata;
        // Rule is sampled once per packet so mid-packet register writes cannot split a decision
        if (r_hidx == '0) begin
          r_rule_addr <= cfg_rule_addr;
          r_rule_mask <= cfg_rule_mask;
          r_ctrl      <= cfg_ctrl[2:0];
        end
        if (r_hidx == LAST_IDX) r_hdr_only <= s_tlast;
        r_hidx <= (s_tlast || r_hidx == LAST_IDX) ? 3'd0 : r_hidx + 3'd1;
      end
      if (r_state == ST_DECIDE) r_ridx <= '0;
      if (w_out_free) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
        case (r_state)
          // Word 0 is loaded straight from DECIDE to save a cycle of replay latency
          ST_DECIDE: begin
            if (!w_drop) begin
              r_m_tdata  <= r_hdr_buf[0];
              r_m_tvalid <= 1'b1;
              r_ridx     <= 3'd1;
            end
          end
          ST_REPLAY: begin
            r_m_tdata  <= r_hdr_buf[r_ridx];
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= r_hdr_only && (r_ridx == LAST_IDX);
            r_ridx     <= r_ridx + 3'd1;
          end
          ST_BODY: begin
            if (w_in_fire) begin
              r_m_tdata  <= s_tdata;
              r_m_tvalid <= 1'b1;
              r_m_tlast  <= s_tlast;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pass_inc) r_pass_cnt <= r_pass_cnt + 32'd1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign s_tready   = w_s_tready;
  assign m_tdata    = r_m_tdata;
  assign m_tvalid   = r_m_tvalid;
  assign m_tlast    = r_m_tlast;
  assign pass_count = r_pass_cnt;
  assign drop_count = r_drop_cnt;
  assign dbg_state  = r_state;

endmodule

// File: doc/ipfw_hdr_filter.md
# ipfw_hdr_filter

Packet-filter datapath stage for the IPFW core, sitting directly downstream of the AXI4-Lite register slave. It consumes the rule registers that slave exposes (match address, mask, control) and applies them to a 32-bit AXI4-Stream of raw IPv4 packets. It buffers the 5-word IPv4 header, decides pass or drop from the source or destination address, then either replays the header and forwards the body, or discards the whole packet. Pass and drop counters go back to the register slave for readback.

## Interface
- DATA_WIDTH, 32, stream width; only 32 is supported.
- HDR_WORDS, 5, header words buffered before the decision (IPv4 IHL=5).
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- cfg_rule_addr  in  32  rule IPv4 address (register slot 0).
- cfg_rule_mask  in  32  compare mask; bit=1 means compare this bit (slot 1).
- cfg_ctrl  in  32  control (slot 2):
  - bit0 enable.
  - bit1 field select: 0=src (word 3), 1=dst (word 4).
  - bit2 action: 1=drop on match, 0=drop on non-match.
- s_tdata  in  32  ingress data; byte 0 of the packet is in [31:24].
- s_tvalid  in  1  ingress valid.
- s_tlast  in  1  ingress last beat.
- s_tready  out  1  ingress ready.
- m_tdata  out  32  egress data.
- m_tvalid  out  1  egress valid.
- m_tlast  out  1  egress last beat.
- m_tready  in  1  egress ready.
- pass_count  out  32  packets forwarded; wraps at 2^32.
- drop_count  out  32  packets dropped, including malformed; wraps at 2^32.

## Operation
- States: HDR, DECIDE, REPLAY, BODY, DROP.
- HDR
  - Accepts beats into hdr_buf[0..4] using word index hidx.
  - Latches cfg_* on the first beat (hidx=0); the config is held for the whole packet.
- Short packet: s_tlast accepted with hidx<4 → packet is malformed.
  - drop_count+1, nothing emitted, return to HDR with hidx=0.
- Word 4 accepted with s_tlast=0 → DECIDE. Word 4 accepted with s_tlast=1 → DECIDE with hdr_only=1.
- DECIDE (1 cycle)
  - sel = field select ? hdr_buf[4] : hdr_buf[3].
  - match = ((sel ^ rule_addr) & rule_mask) == 0.
  - drop = enable & (action ? match : ~match). With enable=0 every packet passes.
  - drop=1, hdr_only=1 → drop_count+1, go to HDR.
  - drop=1, hdr_only=0 → go to DROP.
  - drop=0 → go to REPLAY.
- REPLAY
  - Emits hdr_buf[0..4] in order.
  - m_tlast=1 on word 4 only if hdr_only.
  - When word 4 is taken: hdr_only=1 → pass_count+1, go to HDR; otherwise go to BODY.
- BODY: forwards ingress beats to egress. When the s_tlast beat is accepted: pass_count+1, go to HDR.
- DROP: s_tready=1, beats are discarded. When s_tlast is accepted: drop_count+1, go to HDR.
- Egress uses a single output register:
  - Loaded when the register is empty or m_tready=1.
  - m_tdata/m_tvalid/m_tlast hold stable while m_tvalid=1 and m_tready=0.
- Counters increment at most once per cycle. Only one packet completes per cycle, so the counters never collide.
- A cfg_* change in mid-packet has no effect until the next packet's first beat.

## Timing
- Reset (ARESETN low, asynchronous):
  - State=HDR, hidx=0.
  - s_tready=0 while reset is asserted, then 1 from the first cycle after release.
  - m_tvalid=0, m_tlast=0, m_tdata=0, pass_count=0, drop_count=0.
- Reset asserted mid-packet: the partial packet is abandoned with no counter update. If egress was mid-packet, m_tvalid drops immediately.
- s_tready by state:
  - HDR: 1.
  - DECIDE and REPLAY: 0.
  - BODY: !m_tvalid | m_tready.
  - DROP: 1.
- Latency, word 4 accepted at cycle N:
  - DECIDE at N+1.
  - Word 0 visible on m_tdata/m_tvalid at N+2.
  - Word 4 visible at N+6 if m_tready stays high.
- BODY throughput: 1 beat/cycle with m_tready=1 continuously, with no bubble between the REPLAY→BODY transition and the first body beat.
- Back-to-back packets: the first beat of the next packet can be accepted the cycle after s_tlast.
- Handshake: AXI4-Stream rules. m_tvalid never depends combinationally on m_tready.

## Test plan
- Rule address C0A80001, mask FFFFFFFF, ctrl=5 (enable, src, drop-on-match). Send an 8-word packet with word 3 = C0A80001 → no egress beats; drop_count=1.
- Same rule, word 3 = C0A80002 → all 8 words appear unchanged on egress; m_tlast on word 7; pass_count=1; word 0 at N+2.
- Mask FFFFFF00, ctrl=3 (enable, dst, drop-on-non-match):
  - Word 4 = C0A800FE → passed.
  - Word 4 = C0A90001 → dropped.
  - Counters end at pass=1, drop=1.
- 3-word packet (s_tlast on word 2) → no egress; drop_count+1. The next normal packet passes intact. A 5-word header-only packet with ctrl=0 → 5 beats out, m_tlast on word 4.
- Random m_tready (50%) with back-to-back passing packets → egress data matches a scoreboard; no beat is lost or duplicated; outputs stay stable while stalled.
- Assert ARESETN low in mid-BODY:
  - All outputs reach their reset values immediately.
  - Counters read 0.
  - A fresh packet after release is processed correctly.
